// File: rtl/tm_pkg.sv
// Shared types and constants for the stopwatch controller.
//   sw_state_e : IDLE / RUN / PAUSE
//   *_W        : field widths of ms / sec / min
//   *_MAX_DEF  : default terminal value of each field
package tm_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_e;

  localparam int MS_W  = 10;
  localparam int SEC_W = 6;
  localparam int MIN_W = 7;

  localparam int MS_MAX_DEF  = 999;
  localparam int SEC_MAX_DEF = 59;
  localparam int MIN_MAX_DEF = 99;
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Command/readout bundle of the stopwatch controller.
//   ms_tick, start_stop, lap, clear : one-cycle pulses into the controller
//   ms_out, sec_out, min_out        : displayed time
//   running, lap_active, overflow   : status flags
// master = command source / display, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if;
  import tm_pkg::*;

  logic             ms_tick;
  logic             start_stop;
  logic             lap;
  logic             clear;
  logic [MS_W-1:0]  ms_out;
  logic [SEC_W-1:0] sec_out;
  logic [MIN_W-1:0] min_out;
  logic             running;
  logic             lap_active;
  logic             overflow;

  modport master (
    output ms_tick, start_stop, lap, clear,
    input  ms_out, sec_out, min_out, running, lap_active, overflow
  );

  modport slave (
    input  ms_tick, start_stop, lap, clear,
    output ms_out, sec_out, min_out, running, lap_active, overflow
  );
endinterface

// File: rtl/tm_mod_cnt.sv
// Modulo counter 0..MAX, one field of the stopwatch.
//   clk, rst : clock, async active-high reset
//   en       : advance by one (wraps MAX -> 0)
//   clr      : synchronous zero, wins over en
//   value    : current count
//   carry    : en && value==MAX, feeds the next field's en
module tm_mod_cnt #(
  parameter int WIDTH = 10,
  parameter int MAX   = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] value,
  output logic             carry
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr)     value_d = '0;
    else if (en) value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;
  assign carry = en && (value_q == MAX_V);
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: accumulates ms ticks into min:sec.ms while running,
// with start/stop, lap freeze and clear.
//   clk, rst : clock, async active-high reset
//   bus      : stopwatch_ctrl_if.slave (commands in, display/status out)
module stopwatch_ctrl
  import tm_pkg::*;
#(
  parameter int MS_MAX  = MS_MAX_DEF,
  parameter int SEC_MAX = SEC_MAX_DEF,
  parameter int MIN_MAX = MIN_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  stopwatch_ctrl_if.slave bus
);
  sw_state_e state_q, state_d;

  logic [MS_W-1:0]  live_ms, snap_ms_q, snap_ms_d;
  logic [SEC_W-1:0] live_sec, snap_sec_q, snap_sec_d;
  logic [MIN_W-1:0] live_min, snap_min_q, snap_min_d;
  logic             lap_active_q, lap_active_d;
  logic             overflow_q, overflow_d;
  logic             cnt_en, ms_carry, sec_carry, min_carry;

  // Counting looks at the registered state, so a tick alongside the pause
  // command still counts and one alongside start does not. Clear drops it.
  assign cnt_en = (state_q == RUN) && bus.ms_tick && !bus.clear;

  tm_mod_cnt #(.WIDTH(MS_W), .MAX(MS_MAX)) u_ms (
    .clk(clk), .rst(rst), .en(cnt_en), .clr(bus.clear),
    .value(live_ms), .carry(ms_carry)
  );

  tm_mod_cnt #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .en(ms_carry), .clr(bus.clear),
    .value(live_sec), .carry(sec_carry)
  );

  tm_mod_cnt #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .en(sec_carry), .clr(bus.clear),
    .value(live_min), .carry(min_carry)
  );

  always_comb begin
    state_d      = state_q;
    snap_ms_d    = snap_ms_q;
    snap_sec_d   = snap_sec_q;
    snap_min_d   = snap_min_q;
    lap_active_d = lap_active_q;
    overflow_d   = overflow_q;

    if (bus.clear) begin
      state_d      = IDLE;
      snap_ms_d    = '0;
      snap_sec_d   = '0;
      snap_min_d   = '0;
      lap_active_d = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (bus.start_stop) begin
        unique case (state_q)
          IDLE:    state_d = RUN;
          RUN:     state_d = PAUSE;
          PAUSE:   state_d = RUN;
          default: state_d = IDLE;
        endcase
      end
      // Snapshot takes the live value before this cycle's increment.
      if (bus.lap && (state_q != IDLE)) begin
        if (!lap_active_q) begin
          snap_ms_d    = live_ms;
          snap_sec_d   = live_sec;
          snap_min_d   = live_min;
          lap_active_d = 1'b1;
        end else begin
          lap_active_d = 1'b0;
        end
      end
      if (min_carry) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      snap_ms_q    <= '0;
      snap_sec_q   <= '0;
      snap_min_q   <= '0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_ms_q    <= snap_ms_d;
      snap_sec_q   <= snap_sec_d;
      snap_min_q   <= snap_min_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.ms_out     = lap_active_q ? snap_ms_q  : live_ms;
  assign bus.sec_out    = lap_active_q ? snap_sec_q : live_sec;
  assign bus.min_out    = lap_active_q ? snap_min_q : live_min;
  assign bus.running    = (state_q == RUN);
  assign bus.lap_active = lap_active_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a full-size instance (a) and a tiny-modulus
// instance (b, 0..9 ms / 0..2 s / 0..1 min) share one command stream so the
// wrap/overflow path is reachable in a few cycles. A behavioural model keeps
// elapsed time as a single integer and splits it into fields for the display.
module tb_stopwatch_ctrl;
  import tm_pkg::*;

  typedef logic [25:0] ovec_t; // {min, sec, ms, running, lap_active, overflow}

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0, ss = 1'b0, lp = 1'b0, clr = 1'b0;

  always #5 clk = ~clk;

  stopwatch_ctrl_if bus_a();
  stopwatch_ctrl_if bus_b();

  assign bus_a.ms_tick = tick;  assign bus_b.ms_tick = tick;
  assign bus_a.start_stop = ss; assign bus_b.start_stop = ss;
  assign bus_a.lap = lp;        assign bus_b.lap = lp;
  assign bus_a.clear = clr;     assign bus_b.clear = clr;

  stopwatch_ctrl u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  stopwatch_ctrl #(.MS_MAX(9), .SEC_MAX(2), .MIN_MAX(1)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  // model state per instance: 0 = a, 1 = b; m_state 0 idle, 1 run, 2 pause
  int m_msn[2]  = '{1000, 10};
  int m_secn[2] = '{60, 3};
  int m_minn[2] = '{100, 2};
  int m_live[2], m_snap[2], m_state[2];
  bit m_lap[2], m_ovf[2];

  ovec_t q_a[$];
  ovec_t q_b[$];

  function automatic ovec_t mk(int mn, int sc, int ms, bit r, bit l, bit o);
    return {7'(mn), 6'(sc), 10'(ms), r, l, o};
  endfunction

  function automatic ovec_t obs(int i);
    if (i == 0)
      return {bus_a.min_out, bus_a.sec_out, bus_a.ms_out,
              bus_a.running, bus_a.lap_active, bus_a.overflow};
    return {bus_b.min_out, bus_b.sec_out, bus_b.ms_out,
            bus_b.running, bus_b.lap_active, bus_b.overflow};
  endfunction

  function automatic ovec_t m_exp(int i);
    int d;
    d = m_lap[i] ? m_snap[i] : m_live[i];
    return mk(d / (m_msn[i] * m_secn[i]), (d / m_msn[i]) % m_secn[i],
              d % m_msn[i], m_state[i] == 1, m_lap[i], m_ovf[i]);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_live[i] = 0; m_snap[i] = 0; m_state[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic m_step(int i, bit t, bit s, bit l, bit c);
    int pre_state;
    pre_state = m_state[i];
    if (c) begin
      m_live[i] = 0; m_snap[i] = 0; m_state[i] = 0; m_lap[i] = 0; m_ovf[i] = 0;
    end else begin
      if (l && pre_state != 0) begin
        if (!m_lap[i]) begin m_snap[i] = m_live[i]; m_lap[i] = 1; end
        else m_lap[i] = 0;
      end
      if (t && pre_state == 1) begin
        m_live[i]++;
        if (m_live[i] == m_msn[i] * m_secn[i] * m_minn[i]) begin
          m_live[i] = 0;
          m_ovf[i] = 1;
        end
      end
      if (s) m_state[i] = (pre_state == 1) ? 2 : 1;
    end
  endtask

  task automatic check(string tag, ovec_t o, ovec_t e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // Drive one cycle of commands, queue the model's prediction, then compare
  // both instances once the edge has registered the result.
  task automatic step(bit t, bit s, bit l, bit c);
    tick = t; ss = s; lp = l; clr = c;
    m_step(0, t, s, l, c); q_a.push_back(m_exp(0));
    m_step(1, t, s, l, c); q_b.push_back(m_exp(1));
    @(posedge clk); #1;
    check("cycle_a", obs(0), q_a.pop_front());
    check("cycle_b", obs(1), q_b.pop_front());
    tick = 0; ss = 0; lp = 0; clr = 0;
  endtask

  task automatic ticks(int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    m_reset();
    #1 rst = 1'b1;
    #1;
    check("reset_a", obs(0), mk(0, 0, 0, 0, 0, 0));
    check("reset_b", obs(1), mk(0, 0, 0, 0, 0, 0));
    @(negedge clk) rst = 1'b0;

    // ticks before any start are ignored
    ticks(5);
    check("idle_ticks", obs(0), mk(0, 0, 0, 0, 0, 0));

    step(0, 1, 0, 0);
    ticks(1500);
    check("run_1500", obs(0), mk(0, 1, 500, 1, 0, 0));

    // pause swallows 100 ticks, resume adds 10
    step(0, 1, 0, 0);
    ticks(100);
    check("paused", obs(0), mk(0, 1, 500, 0, 0, 0));
    step(0, 1, 0, 0);
    ticks(10);
    check("resumed", obs(0), mk(0, 1, 510, 1, 0, 0));

    // lap freezes 2.000 while live keeps counting
    ticks(490);
    check("at_2s", obs(0), mk(0, 2, 0, 1, 0, 0));
    step(0, 0, 1, 0);
    ticks(300);
    check("lap_hold", obs(0), mk(0, 2, 0, 1, 1, 0));
    step(0, 0, 1, 0);
    check("lap_release", obs(0), mk(0, 2, 300, 1, 0, 0));

    // tick with pause in RUN counts; tick with resume in PAUSE does not
    step(1, 1, 0, 0);
    check("ss_tick_run", obs(0), mk(0, 2, 301, 0, 0, 0));
    step(1, 1, 0, 0);
    check("ss_tick_pause", obs(0), mk(0, 2, 301, 1, 0, 0));

    // wrap on the small instance: 1:2.9 -> 0:0.0 with overflow, sticky
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(59);
    check("pre_wrap_b", obs(1), mk(1, 2, 9, 1, 0, 0));
    ticks(1);
    check("wrap_b", obs(1), mk(0, 0, 0, 1, 0, 1));
    ticks(1);
    check("post_wrap_b", obs(1), mk(0, 0, 1, 1, 0, 1));

    // clear beats start_stop, lap and tick in the same cycle
    step(0, 0, 1, 0);
    check("lap_on_b", obs(1), mk(0, 0, 1, 1, 1, 1));
    step(1, 1, 1, 1);
    check("clear_a", obs(0), mk(0, 0, 0, 0, 0, 0));
    check("clear_b", obs(1), mk(0, 0, 0, 0, 0, 0));

    // async reset mid-count, sampled before the next clock edge
    step(0, 1, 0, 0);
    ticks(7123);
    check("at_7123", obs(0), mk(0, 7, 123, 1, 0, 0));
    #2 rst = 1'b1;
    #1;
    check("async_rst_a", obs(0), mk(0, 0, 0, 0, 0, 0));
    check("async_rst_b", obs(1), mk(0, 0, 0, 0, 0, 0));
    m_reset();
    @(negedge clk) rst = 1'b0;
    ticks(3);
    check("after_rst", obs(0), mk(0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Stopwatch controller downstream of the millisecond measurement stage. It consumes the one-cycle millisecond tick and accumulates elapsed time as minutes, seconds and milliseconds. The count is gated by start/stop and clear commands. A lap function freezes the displayed value while counting continues underneath, and the outputs feed the display/readout stage.

Parameters:
MS_MAX, 999, terminal value of the millisecond field
SEC_MAX, 59, terminal value of the seconds field
MIN_MAX, 99, terminal value of the minutes field

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
ms_tick  input  1  one-cycle pulse, one per elapsed millisecond, from the ms measurement stage
start_stop  input  1  one-cycle command pulse (pre-synchronised, debounced): toggle run/pause
lap  input  1  one-cycle command pulse: freeze or release the displayed value
clear  input  1  one-cycle command pulse: stop and zero everything
ms_out  output  10  displayed milliseconds, 0..MS_MAX
sec_out  output  6  displayed seconds, 0..SEC_MAX
min_out  output  7  displayed minutes, 0..MIN_MAX
running  output  1  high while in RUN
lap_active  output  1  high while the display is frozen
overflow  output  1  sticky; set when the count wraps past MIN_MAX:SEC_MAX.MS_MAX

Behaviour:
- Reset (async, rst=1): state=IDLE; live and snapshot counters all 0. Outputs ms_out=0, sec_out=0, min_out=0, running=0, lap_active=0, overflow=0.
- All outputs are registered or derived directly from registers. ms_tick accepted at edge n is visible on outputs after edge n (next cycle).
- State machine, IDLE / RUN / PAUSE:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN.
  - Any state: clear -> IDLE.
- Command priority in one cycle: clear > start_stop > lap. Lower-priority commands in the same cycle are still honoured if legal in the current state; clear discards all others.
- Counting: the live counter increments only when state==RUN (the registered state) and ms_tick=1.
  - ms wraps MS_MAX->0 with carry into sec.
  - sec wraps SEC_MAX->0 with carry into min.
  - min wraps MIN_MAX->0 and sets overflow.
- A tick in the same cycle as start_stop in RUN is counted. A tick in the same cycle as start_stop in IDLE or PAUSE is not counted.
- Ticks in IDLE or PAUSE are ignored.
- Lap:
  - In RUN or PAUSE with lap_active=0: copy the current live registers (pre-increment value of that cycle) into the snapshot and set lap_active=1.
  - With lap_active=1: clear lap_active, so outputs show live values again.
  - lap in IDLE is ignored.
- Output mux: lap_active ? snapshot : live.
- clear: zeroes live, snapshot, lap_active and overflow; state=IDLE; the same-cycle ms_tick is discarded.
- overflow stays set until clear or rst. Counting continues after the wrap.
- Reset asserted mid-count forces the reset values immediately and asynchronously; no partial state survives.

Decomposition:
- Shared package tm_pkg:
  - state enum {IDLE, RUN, PAUSE}
  - width constants MS_W=10, SEC_W=6, MIN_W=7
  - default terminal constants
- Sub-module tm_mod_cnt: parameterised modulo counter with WIDTH and MAX, inputs en/clr, outputs value and carry (carry = en && value==MAX). Three instances are cascaded with carry chaining for ms, sec and min.

Test Plan:
- Reset, then 5 ms_tick with no start -> outputs 00:00.000, running=0.
- start_stop, then 1500 ticks -> ms_out=500, sec_out=1, min_out=0, running=1.
- start_stop (pause), 100 ticks, start_stop, 10 ticks -> count advances only by 10.
- Running at 00:02.000, lap, 300 ticks -> display held at 2.000 with lap_active=1; lap again -> display 00:02.300.
- Preload by ticking to 99:59.999, 1 tick -> outputs 00:00.000, overflow=1; further tick -> 00:00.001, overflow still 1.
- clear asserted together with start_stop and ms_tick while in RUN with lap_active=1 -> IDLE, all outputs 0, lap_active=0, overflow=0.
- rst asserted mid-count at 00:07.123 -> outputs 0 asynchronously, before the next clock edge.
